// File: rtl/cache_pkg.sv
// Shared definitions for the cache: data-array replace opcodes, controller
// states and the address field split derived from the default geometry.
package cache_pkg;

    localparam int DATA_SIZE_DEF  = 32;
    localparam int BLOCK_SIZE_DEF = 6;
    localparam int INDEX_SIZE_DEF = 7;
    localparam int TAG_SIZE_DEF   = 17;

    localparam int ADDR_W    = TAG_SIZE_DEF + INDEX_SIZE_DEF + BLOCK_SIZE_DEF + 2;
    localparam int BLOCK_LSB = 2;
    localparam int INDEX_LSB = BLOCK_LSB + BLOCK_SIZE_DEF;
    localparam int TAG_LSB   = INDEX_LSB + INDEX_SIZE_DEF;

    typedef enum logic [2:0] {
        OP_CLR     = 3'b000,
        OP_WR_HIT  = 3'b001,
        OP_RD      = 3'b010,
        OP_FILL_WR = 3'b011,
        OP_FILL_RD = 3'b100,
        OP_WB      = 3'b101,
        OP_NOP     = 3'b110
    } replace_op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOOKUP,
        S_HIT_RD,
        S_HIT_WR,
        S_WB_CAP,
        S_WB_WAIT,
        S_FILL,
        S_UPDATE,
        S_RESP
    } ctrl_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (&value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/cache_perf_cnt.sv
// Three saturating 32-bit event counters (hits, misses, writebacks).
module cache_perf_cnt
    import cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc_hit,
    input  logic        inc_miss,
    input  logic        inc_wb,
    output logic [31:0] perf_hits,
    output logic [31:0] perf_misses,
    output logic [31:0] perf_wbs
);

    // Count events, clearing on reset and holding at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_hits   <= '0;
            perf_misses <= '0;
            perf_wbs    <= '0;
        end else begin
            if (inc_hit)  perf_hits   <= sat_inc(perf_hits);
            if (inc_miss) perf_misses <= sat_inc(perf_misses);
            if (inc_wb)   perf_wbs    <= sat_inc(perf_wbs);
        end
    end

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Single-requester cache controller: latches one load/store, checks the tag
// array, and sequences the data array through hit, writeback and refill steps
// while handshaking line transfers with the memory master.
// Optional performance counters are built when CACHE_CTRL_PERF_EN is defined.
module cache_ctrl_fsm
    import cache_pkg::*;
#(
    parameter int DATA_SIZE  = 32,
    parameter int BLOCK_SIZE = 6,
    parameter int INDEX_SIZE = 7,
    parameter int TAG_SIZE   = 17
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        cpu_req_valid,
    output logic                                        cpu_req_ready,
    input  logic                                        cpu_req_we,
    input  logic [TAG_SIZE+INDEX_SIZE+BLOCK_SIZE+1:0]   cpu_req_addr,
    input  logic [DATA_SIZE-1:0]                        cpu_req_wdata,
    output logic                                        cpu_resp_valid,
    output logic [DATA_SIZE-1:0]                        cpu_rdata,
    input  logic                                        tag_hit,
    input  logic                                        tag_dirty,
    output logic                                        tag_update,
    output logic                                        tag_set_dirty,
    output logic                                        tag_clr,
    output logic [2:0]                                  da_replace,
    output logic [INDEX_SIZE-1:0]                       da_index,
    output logic [BLOCK_SIZE-1:0]                       da_block,
    output logic [TAG_SIZE-1:0]                         da_tag,
    output logic [DATA_SIZE-1:0]                        da_wdata,
    input  logic [DATA_SIZE-1:0]                        da_rdata,
    output logic                                        mem_rd_req,
    output logic                                        mem_wr_req,
    input  logic                                        mem_ack
`ifdef CACHE_CTRL_PERF_EN
    ,
    output logic [31:0]                                 perf_hits,
    output logic [31:0]                                 perf_misses,
    output logic [31:0]                                 perf_wbs
`endif
);

    localparam int IDX_LSB = 2 + BLOCK_SIZE;
    localparam int TG_LSB  = IDX_LSB + INDEX_SIZE;

    ctrl_state_e            state;
    ctrl_state_e            state_next;
    replace_op_e            op;
    logic                   accept;
    logic                   we_q;
    logic [INDEX_SIZE-1:0]  index_q;
    logic [BLOCK_SIZE-1:0]  block_q;
    logic [TAG_SIZE-1:0]    tag_q;
    logic [DATA_SIZE-1:0]   wdata_q;
    logic [DATA_SIZE-1:0]   rdata_q;
    logic                   unused_addr_lsb;

    // Byte-within-word bits carry no meaning for word accesses.
    assign unused_addr_lsb = ^cpu_req_addr[1:0];

    assign accept = (state == S_IDLE) && cpu_req_valid && !rst;

    // State register; reset from any state returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Request latch, loaded on the accept cycle and held until the response.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= cpu_req_we;
            index_q <= cpu_req_addr[TG_LSB-1:IDX_LSB];
            block_q <= cpu_req_addr[IDX_LSB-1:2];
            tag_q   <= cpu_req_addr[TG_LSB+TAG_SIZE-1:TG_LSB];
            wdata_q <= cpu_req_wdata;
        end
    end

    // Load data captured while the array presents the addressed word.
    always_ff @(posedge clk) begin
        if (rst)                    rdata_q <= '0;
        else if (state == S_HIT_RD) rdata_q <= da_rdata;
    end

    // Next-state and output decode; reset forces the array clear and idles everything else.
    always_comb begin
        state_next     = state;
        op             = OP_NOP;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        tag_update     = 1'b0;
        tag_set_dirty  = 1'b0;
        tag_clr        = 1'b0;
        mem_rd_req     = 1'b0;
        mem_wr_req     = 1'b0;
        cpu_rdata      = rdata_q;
        da_index       = index_q;
        da_block       = block_q;
        da_tag         = tag_q;
        da_wdata       = wdata_q;

        case (state)
            S_IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) state_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (tag_hit)        state_next = we_q ? S_HIT_WR : S_HIT_RD;
                else if (tag_dirty) state_next = S_WB_CAP;
                else                state_next = S_FILL;
            end
            S_HIT_RD: begin
                op         = OP_RD;
                state_next = S_RESP;
            end
            S_HIT_WR: begin
                op            = OP_WR_HIT;
                tag_set_dirty = 1'b1;
                state_next    = S_RESP;
            end
            S_WB_CAP: begin
                op         = OP_WB;
                state_next = S_WB_WAIT;
            end
            S_WB_WAIT: begin
                mem_wr_req = 1'b1;
                if (mem_ack) state_next = S_FILL;
            end
            S_FILL: begin
                mem_rd_req = 1'b1;
                if (mem_ack) state_next = S_UPDATE;
            end
            S_UPDATE: begin
                op            = we_q ? OP_FILL_WR : OP_FILL_RD;
                tag_update    = 1'b1;
                tag_set_dirty = we_q;
                // A refilled load re-reads its word through the normal hit path.
                state_next    = we_q ? S_RESP : S_HIT_RD;
            end
            S_RESP: begin
                cpu_resp_valid = 1'b1;
                state_next     = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        if (rst) begin
            state_next     = S_IDLE;
            op             = OP_CLR;
            cpu_req_ready  = 1'b0;
            cpu_resp_valid = 1'b0;
            tag_update     = 1'b0;
            tag_set_dirty  = 1'b0;
            tag_clr        = 1'b1;
            mem_rd_req     = 1'b0;
            mem_wr_req     = 1'b0;
            cpu_rdata      = '0;
            da_index       = '0;
            da_block       = '0;
            da_tag         = '0;
            da_wdata       = '0;
        end
    end

    assign da_replace = op;

`ifdef CACHE_CTRL_PERF_EN
    cache_perf_cnt u_perf (
        .clk         (clk),
        .rst         (rst),
        .inc_hit     ((state == S_LOOKUP) && tag_hit),
        .inc_miss    ((state == S_LOOKUP) && !tag_hit),
        .inc_wb      (state == S_WB_CAP),
        .perf_hits   (perf_hits),
        .perf_misses (perf_misses),
        .perf_wbs    (perf_wbs)
    );
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Bench for cache_ctrl_fsm: table of transactions with a memory responder and
// a response scoreboard, plus hand sequences for reset and request corner cases.
module tb_cache_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_valid;
    logic        cpu_req_ready;
    logic        cpu_req_we;
    logic [31:0] cpu_req_addr;
    logic [31:0] cpu_req_wdata;
    logic        cpu_resp_valid;
    logic [31:0] cpu_rdata;
    logic        tag_hit;
    logic        tag_dirty;
    logic        tag_update;
    logic        tag_set_dirty;
    logic        tag_clr;
    logic [2:0]  da_replace;
    logic [6:0]  da_index;
    logic [5:0]  da_block;
    logic [16:0] da_tag;
    logic [31:0] da_wdata;
    logic [31:0] da_rdata;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic        mem_ack;
`ifdef CACHE_CTRL_PERF_EN
    logic [31:0] perf_hits;
    logic [31:0] perf_misses;
    logic [31:0] perf_wbs;
`endif

    cache_ctrl_fsm dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_we     (cpu_req_we),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_rdata      (cpu_rdata),
        .tag_hit        (tag_hit),
        .tag_dirty      (tag_dirty),
        .tag_update     (tag_update),
        .tag_set_dirty  (tag_set_dirty),
        .tag_clr        (tag_clr),
        .da_replace     (da_replace),
        .da_index       (da_index),
        .da_block       (da_block),
        .da_tag         (da_tag),
        .da_wdata       (da_wdata),
        .da_rdata       (da_rdata),
        .mem_rd_req     (mem_rd_req),
        .mem_wr_req     (mem_wr_req),
        .mem_ack        (mem_ack)
`ifdef CACHE_CTRL_PERF_EN
        ,
        .perf_hits      (perf_hits),
        .perf_misses    (perf_misses),
        .perf_wbs       (perf_wbs)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        hit;
        logic        dirty;
        logic [31:0] rdata;
        int          wb_wait;
        int          rd_wait;
        int          exp_lat;
        int          n_rd;
        int          n_wrhit;
        int          n_fillwr;
        int          n_fillrd;
        int          n_wb;
        int          n_upd;
        int          n_setd;
        int          n_wrcyc;
        int          n_rdcyc;
    } vec_t;

    typedef struct {
        int          lat;
        logic        we;
        logic [31:0] rdata;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic hit, input logic dirty, input logic [31:0] rdata,
                                input int wbw, input int rdw, input int lat,
                                input int nrd, input int nwrhit, input int nfillwr, input int nfillrd,
                                input int nwb, input int nupd, input int nsetd, input int nwrc, input int nrdc);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.hit = hit; v.dirty = dirty; v.rdata = rdata;
        v.wb_wait = wbw; v.rd_wait = rdw; v.exp_lat = lat;
        v.n_rd = nrd; v.n_wrhit = nwrhit; v.n_fillwr = nfillwr; v.n_fillrd = nfillrd;
        v.n_wb = nwb; v.n_upd = nupd; v.n_setd = nsetd; v.n_wrcyc = nwrc; v.n_rdcyc = nrdc;
        return v;
    endfunction

    // Pop the oldest expected response and compare it with what the DUT shows now.
    task automatic sb_check(input int k);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_unexpected_resp", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("resp_latency", k, e.lat);
            if (!e.we) chk("resp_rdata", cpu_rdata, e.rdata);
        end
    endtask

    // One full transaction with a memory responder answering after the row's wait counts.
    task automatic run_vec(input int id, input vec_t v);
        int   k, wr_age, rd_age;
        int   c_rd, c_wrhit, c_fillwr, c_fillrd, c_wb, c_upd, c_setd, c_wrc, c_rdc, c_both, c_clr;
        bit   done;
        exp_t e;
        k = 1; wr_age = 0; rd_age = 0; done = 0;
        c_rd = 0; c_wrhit = 0; c_fillwr = 0; c_fillrd = 0; c_wb = 0;
        c_upd = 0; c_setd = 0; c_wrc = 0; c_rdc = 0; c_both = 0; c_clr = 0;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_we    = v.we;
        cpu_req_addr  = v.addr;
        cpu_req_wdata = v.wdata;
        tag_hit       = v.hit;
        tag_dirty     = v.dirty;
        da_rdata      = v.rdata;
        #1 chk($sformatf("v%0d_ready", id), cpu_req_ready, 1'b1);
        @(posedge clk);
        e.lat = v.exp_lat; e.we = v.we; e.rdata = v.rdata;
        sb.push_back(e);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_addr  = 32'h0;
        cpu_req_wdata = 32'h0;
        while (!done && k < 100) begin
            #1;
            if (k == 1) begin
                chk($sformatf("v%0d_da_block", id), da_block, v.addr[7:2]);
                chk($sformatf("v%0d_da_index", id), da_index, v.addr[14:8]);
                chk($sformatf("v%0d_da_tag", id), da_tag, v.addr[31:15]);
                chk($sformatf("v%0d_da_wdata", id), da_wdata, v.wdata);
            end
            mem_ack = 1'b0;
            if (mem_wr_req) begin
                c_wrc++;
                if (wr_age == v.wb_wait) mem_ack = 1'b1;
                wr_age++;
            end
            if (mem_rd_req) begin
                c_rdc++;
                if (rd_age == v.rd_wait) mem_ack = 1'b1;
                rd_age++;
            end
            if (mem_rd_req && mem_wr_req) c_both++;
            case (da_replace)
                3'b000: c_clr++;
                3'b001: c_wrhit++;
                3'b010: c_rd++;
                3'b011: c_fillwr++;
                3'b100: c_fillrd++;
                3'b101: c_wb++;
                default: ;
            endcase
            if (tag_update)    c_upd++;
            if (tag_set_dirty) c_setd++;
            if (cpu_resp_valid) begin
                sb_check(k);
                done = 1;
            end
            @(negedge clk);
            k++;
        end
        mem_ack = 1'b0;
        if (!done) chk($sformatf("v%0d_resp_timeout", id), 32'd0, 32'd1);
        chk($sformatf("v%0d_op_rd", id), c_rd, v.n_rd);
        chk($sformatf("v%0d_op_wrhit", id), c_wrhit, v.n_wrhit);
        chk($sformatf("v%0d_op_fillwr", id), c_fillwr, v.n_fillwr);
        chk($sformatf("v%0d_op_fillrd", id), c_fillrd, v.n_fillrd);
        chk($sformatf("v%0d_op_wb", id), c_wb, v.n_wb);
        chk($sformatf("v%0d_op_clr", id), c_clr, 0);
        chk($sformatf("v%0d_tag_update", id), c_upd, v.n_upd);
        chk($sformatf("v%0d_tag_set_dirty", id), c_setd, v.n_setd);
        chk($sformatf("v%0d_wr_req_cycles", id), c_wrc, v.n_wrcyc);
        chk($sformatf("v%0d_rd_req_cycles", id), c_rdc, v.n_rdcyc);
        chk($sformatf("v%0d_req_overlap", id), c_both, 0);
        #1 chk($sformatf("v%0d_idle_after", id), cpu_req_ready, 1'b1);
    endtask

    initial begin
        int   k, n_acc, k_resp;
        bit   got;
        exp_t e;

        //           we    addr          wdata         hit   dirty rdata        wbw rdw lat rd wh fw fr wb up sd wrc rdc
        vecs[0] = mk(1'b0, 32'h0000_1004, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1] = mk(1'b1, 32'h0000_2008, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0,        0, 0, 3, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        vecs[2] = mk(1'b0, 32'h1234_5678, 32'h0,        1'b0, 1'b0, 32'h0BADF00D, 0, 4, 9, 1, 0, 0, 1, 0, 1, 0, 0, 5);
        vecs[3] = mk(1'b1, 32'hFFFF_FFFC, 32'hCAFEF00D, 1'b0, 1'b1, 32'h0,        2, 1, 9, 0, 0, 1, 0, 1, 1, 1, 3, 2);
        vecs[4] = mk(1'b0, 32'h8000_0100, 32'h0,        1'b0, 1'b1, 32'h13579BDF, 0, 0, 7, 1, 0, 0, 1, 1, 1, 0, 1, 1);
        vecs[5] = mk(1'b1, 32'h0000_0000, 32'h00000000, 1'b0, 1'b0, 32'h0,        0, 0, 4, 0, 0, 1, 0, 0, 1, 1, 0, 1);
        vecs[6] = mk(1'b0, 32'hFFFF_FFFC, 32'h0,        1'b1, 1'b0, 32'hFFFFFFFF, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        rst = 1'b1; cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = 32'h0;
        cpu_req_wdata = 32'h0; tag_hit = 1'b0; tag_dirty = 1'b0; da_rdata = 32'h0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_da_replace", da_replace, 3'b000);
        chk("rst_tag_clr", tag_clr, 1'b1);
        chk("rst_ready", cpu_req_ready, 1'b0);
        chk("rst_rdata", cpu_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", cpu_req_ready, 1'b1);
        chk("post_rst_op", da_replace, 3'b110);
        chk("post_rst_tag_clr", tag_clr, 1'b0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset held for three cycles while a refill request is outstanding.
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h0000_4440;
        tag_hit = 1'b0; tag_dirty = 1'b0; da_rdata = 32'h5555AAAA;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            #1 if (mem_rd_req) got = 1;
        end
        chk("rstfill_in_fill", got, 1'b1);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("rstfill_op_c%0d", i), da_replace, 3'b000);
            chk($sformatf("rstfill_tag_clr_c%0d", i), tag_clr, 1'b1);
            chk($sformatf("rstfill_rd_req_c%0d", i), mem_rd_req, 1'b0);
            chk($sformatf("rstfill_ready_c%0d", i), cpu_req_ready, 1'b0);
            chk($sformatf("rstfill_misc_c%0d", i),
                {cpu_resp_valid, tag_update, tag_set_dirty, mem_wr_req, da_index}, 32'h0);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        chk("rstfill_ready_after", cpu_req_ready, 1'b1);
        chk("rstfill_op_after", da_replace, 3'b110);
        chk("rstfill_rd_req_after", mem_rd_req, 1'b0);

        // Stray ack in IDLE must not move the controller.
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("stray_ack_ready", cpu_req_ready, 1'b1);
        chk("stray_ack_reqs", {mem_rd_req, mem_wr_req}, 2'b00);
        chk("stray_ack_op", da_replace, 3'b110);

        // Request held valid across a clean load miss: exactly one accept per response.
        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h0000_0A0C;
        tag_hit = 1'b0; tag_dirty = 1'b0; da_rdata = 32'h2468ACE0;
        #1 chk("held_first_ready", cpu_req_ready, 1'b1);
        e.lat = 6; e.we = 1'b0; e.rdata = 32'h2468ACE0;
        sb.push_back(e);
        @(negedge clk);
        k = 1; n_acc = 0; k_resp = 0;
        while (k_resp == 0 && k < 40) begin
            #1;
            mem_ack = mem_rd_req && (k == 3);
            if (cpu_req_ready) n_acc++;
            if (cpu_resp_valid) begin
                sb_check(k);
                k_resp = k;
            end
            @(negedge clk);
            k++;
        end
        mem_ack = 1'b0;
        chk("held_no_extra_accept", n_acc, 0);
        chk("held_resp_seen", k_resp, 6);
        tag_hit = 1'b1;
        #1 chk("held_next_accept", cpu_req_ready, 1'b1);
        e.lat = 3; e.we = 1'b0; e.rdata = 32'h2468ACE0;
        sb.push_back(e);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        got = 0;
        for (int i = 1; i < 10 && !got; i++) begin
            #1;
            if (cpu_resp_valid) begin
                sb_check(i);
                got = 1;
            end
            @(negedge clk);
        end
        chk("held_second_resp", got, 1'b1);
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_fsm.md
Name: cache_ctrl_fsm

Overview:
Single-requester cache controller that sequences the set-associative data array and tag array. Accepts one processor load/store at a time and checks hit/dirty from the tag array. Issues the data-array replace opcode for each step: hit read, hit write, dirty writeback, refill with or without merged store. Handshakes line-wide reads/writes with the AXI-side memory master.

Parameters:
DATA_SIZE, 32, processor word width
BLOCK_SIZE, 6, log2 words per line
INDEX_SIZE, 7, log2 sets
TAG_SIZE, 17, tag bits; address width = TAG_SIZE+INDEX_SIZE+BLOCK_SIZE+2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cpu_req_valid  in  1  processor request valid
cpu_req_ready  out  1  high only in IDLE
cpu_req_we  in  1  1=store, 0=load
cpu_req_addr  in  ADDR_W  byte address
cpu_req_wdata  in  DATA_SIZE  store data
cpu_resp_valid  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_SIZE  load data, valid with cpu_resp_valid
tag_hit  in  1  lookup hit for da_index/da_tag (combinational from tag array)
tag_dirty  in  1  selected victim dirty
tag_update  out  1  write tag/valid for victim way
tag_set_dirty  out  1  set dirty bit (hit write, or refill with store)
tag_clr  out  1  invalidate all tags
da_replace  out  3  data-array opcode
da_index  out  INDEX_SIZE  latched index
da_block  out  BLOCK_SIZE  latched word offset
da_tag  out  TAG_SIZE  latched tag
da_wdata  out  DATA_SIZE  latched store data
da_rdata  in  DATA_SIZE  data-array word read (valid when opcode = RD)
mem_rd_req  out  1  line refill request, held until mem_ack
mem_wr_req  out  1  line writeback request, held until mem_ack
mem_ack  in  1  completes the pending mem request

Behaviour:
- Opcodes: CLR=000 (clear array), WR_HIT=001, RD=010, FILL_WR=011, FILL_RD=100, WB=101, NOP=110. Never drive CLR outside reset.
- Reset (any state, any cycle): next state IDLE.
- While rst is high: da_replace=CLR, tag_clr=1, all other outputs 0, cpu_rdata=0.
- Pending mem request is dropped on reset without waiting for ack.
- Request latch: address fields and wdata are registered on the accept cycle (valid & ready). They are held until RESP.
- States and transitions:
  - IDLE: ready=1, opcode NOP. On accept -> LOOKUP.
  - LOOKUP: opcode NOP. hit & !we -> HIT_RD. hit & we -> HIT_WR. miss & dirty -> WB_CAP. miss & !dirty -> FILL.
  - HIT_RD: opcode RD, cpu_rdata <= da_rdata. -> RESP.
  - HIT_WR: opcode WR_HIT, tag_set_dirty=1. -> RESP.
  - WB_CAP: opcode WB for one cycle, capturing the victim line into the array's writeback register. -> WB_WAIT.
  - WB_WAIT: mem_wr_req=1, opcode NOP. On mem_ack -> FILL.
  - FILL: mem_rd_req=1, opcode NOP. On mem_ack -> UPDATE.
  - UPDATE: opcode FILL_WR if we, else FILL_RD; tag_update=1; tag_set_dirty=we. we -> RESP, else -> HIT_RD (re-read the refilled word).
  - RESP: cpu_resp_valid=1 for one cycle. -> IDLE.
- A mem request rises on state entry. An ack in that same cycle completes it; minimum one cycle in WB_WAIT/FILL.
- Latency from accept cycle T: hit load/store resp at T+3. Clean miss load resp at T+5+refill wait. Dirty miss adds 2+writeback wait.
- cpu_req_valid outside IDLE is ignored (ready=0). Requests may arrive in the same cycle RESP ends; they are accepted the following cycle in IDLE.
- mem_ack while no request is pending is ignored.
- mem_rd_req and mem_wr_req are never high together.

Optional Feature:
CACHE_CTRL_PERF_EN defined: adds outputs perf_hits, perf_misses, perf_wbs (32 bits each), reset to 0 by rst.
- hits/misses increment on LOOKUP exit; wbs increments on WB_CAP.
- All three saturate at all-ones.
Undefined: the ports and counters are absent, with identical functional behaviour.

Decomposition:
- Package cache_pkg: replace_op_e enum (the seven opcodes), ctrl_state_e enum, ADDR_W and field-split localparams derived from the parameters.
- Shared by the data array, tag array and this block.
- Natural sub-module: cache_perf_cnt (three saturating counters), instantiated only under CACHE_CTRL_PERF_EN.

Test Plan:
- Reset held 3 cycles mid-FILL with mem_rd_req=1 -> da_replace=000 and tag_clr=1 during reset; mem_rd_req=0 first cycle; IDLE after release, ready=1.
- Load 0x0000_1004, tag_hit=1, da_rdata=0xDEADBEEF -> da_block=1, opcode 010 at T+2, resp_valid and cpu_rdata=0xDEADBEEF at T+3.
- Store 0xA5A5A5A5, tag_hit=1 -> opcode 001 and tag_set_dirty=1 at T+2, resp at T+3, no mem requests.
- Load miss, tag_dirty=0, mem_ack 4 cycles after mem_rd_req -> no mem_wr_req; UPDATE opcode 100 with tag_update=1, then opcode 010, then resp.
- Store miss, tag_dirty=1 -> opcode 101 one cycle, mem_wr_req until ack, then mem_rd_req until ack, UPDATE opcode 011 with tag_set_dirty=1, resp next.
- cpu_req_valid held high during a miss, plus spurious mem_ack in IDLE -> exactly one acceptance per RESP; no state change from the stray ack.
